// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter.
package dram_arb_pkg;

    localparam int unsigned DEF_AW     = 16;
    localparam int unsigned DEF_DW     = 16;
    localparam int unsigned WR_LATENCY = 3;
    localparam int unsigned RD_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_ADDR,
        ST_W_LATCH,
        ST_W_DATA,
        ST_R_ADDR,
        ST_R_RESP
    } dram_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IW        = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IW-1:0]        last_grant,
    output logic [IW-1:0]        gnt_idx,
    output logic                 any_req
);

    int unsigned cand;

    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            cand = (32'(last_grant) + k) % NUM_CORES;
            if (!any_req && req[IW'(cand)]) begin
                any_req = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port DRAM between NUM_CORES ports.
// Optional write-address cache enabled by defining DRAM_ARB_ADDR_CACHE_EN.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    req,
    input  logic [NUM_CORES-1:0]    we,
    input  logic [NUM_CORES*AW-1:0] addr,
    input  logic [NUM_CORES*DW-1:0] wdata,
    output logic [NUM_CORES-1:0]    ack,
    output logic [DW-1:0]           rdata,
    output logic                    busy,
    output logic                    dram_write_en,
    output logic                    dram_addr_write_en,
    output logic [DW-1:0]           dram_data_in,
    input  logic [DW-1:0]           dram_data_out
);

    localparam int unsigned IW = $clog2(NUM_CORES);

    dram_arb_state_t state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d, last_grant_q, last_grant_d, arb_idx;
    logic            arb_any, sel_we, cache_hit;
    logic [AW-1:0]   addr_q, addr_d, sel_addr;
    logic [DW-1:0]   wdata_q, wdata_d, sel_wdata;

    logic [NUM_CORES-1:0] ack_q, ack_d;
    logic                 busy_q, busy_d, dwe_q, dwe_d, dawe_q, dawe_d;
    logic [DW-1:0]        ddin_q, ddin_d;

    logic [AW-1:0] addr_arr  [NUM_CORES];
    logic [DW-1:0] wdata_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign addr_arr[g]  = addr[g*AW +: AW];
        assign wdata_arr[g] = wdata[g*DW +: DW];
    end

    rr_arbiter #(.NUM_CORES(NUM_CORES), .IW(IW)) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_idx    (arb_idx),
        .any_req    (arb_any)
    );

    assign sel_we    = we[arb_idx];
    assign sel_addr  = addr_arr[arb_idx];
    assign sel_wdata = wdata_arr[arb_idx];

`ifdef DRAM_ARB_ADDR_CACHE_EN
    // DRAM addr_op still holds the last latched write address; skip re-sending it.
    logic [AW-1:0] last_waddr_q, last_waddr_d;
    logic          lw_valid_q, lw_valid_d;

    always_comb begin
        last_waddr_d = last_waddr_q;
        lw_valid_d   = lw_valid_q;
        if (state_q == ST_W_LATCH) begin
            last_waddr_d = addr_q;
            lw_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_waddr_q <= '0;
            lw_valid_q   <= 1'b0;
        end else begin
            last_waddr_q <= last_waddr_d;
            lw_valid_q   <= lw_valid_d;
        end
    end

    assign cache_hit = lw_valid_q && (sel_addr == last_waddr_q);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gidx_d       = arb_idx;
                    last_grant_d = arb_idx;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    if (!sel_we)        state_d = ST_R_ADDR;
                    else if (cache_hit) state_d = ST_W_DATA;
                    else                state_d = ST_W_ADDR;
                end
            end
            ST_W_ADDR:  state_d = ST_W_LATCH;
            ST_W_LATCH: state_d = ST_W_DATA;
            ST_R_ADDR:  state_d = ST_R_RESP;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs for the next cycle, decoded from next state and latched request.
    always_comb begin
        ack_d  = '0;
        dwe_d  = 1'b0;
        dawe_d = 1'b0;
        ddin_d = '0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_W_ADDR: begin
                dawe_d = 1'b1;
                ddin_d = DW'(addr_d);
            end
            ST_W_LATCH, ST_R_ADDR: ddin_d = DW'(addr_d);
            ST_W_DATA: begin
                dwe_d         = 1'b1;
                ddin_d        = wdata_d;
                ack_d[gidx_d] = 1'b1;
            end
            ST_R_RESP: ack_d[gidx_d] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gidx_q       <= '0;
            last_grant_q <= IW'(NUM_CORES - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            dwe_q        <= 1'b0;
            dawe_q       <= 1'b0;
            ddin_q       <= '0;
        end else begin
            state_q      <= state_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            dwe_q        <= dwe_d;
            dawe_q       <= dawe_d;
            ddin_q       <= ddin_d;
        end
    end

    assign ack                = ack_q;
    assign busy               = busy_q;
    assign dram_write_en      = dwe_q;
    assign dram_addr_write_en = dawe_q;
    assign dram_data_in       = ddin_q;
    // DRAM registers the read word at the end of R_ADDR, so it is passed straight through.
    assign rdata              = (state_q == ST_R_RESP) ? dram_data_out : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized bench for dram_arbiter with a transaction-level reference model and a DRAM model.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = DEF_AW;
    localparam int unsigned DW = DEF_DW;
`ifdef DRAM_ARB_ADDR_CACHE_EN
    localparam int unsigned HIT_LAT = 1;
`else
    localparam int unsigned HIT_LAT = WR_LATENCY;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] wdata_bus;
    logic [AW-1:0]   c_addr  [N];
    logic [DW-1:0]   c_wdata [N];
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata, dram_data_in, dram_data_out;
    logic            busy, dram_write_en, dram_addr_write_en;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign addr_bus[g*AW +: AW]  = c_addr[g];
        assign wdata_bus[g*DW +: DW] = c_wdata[g];
    end

    dram_arbiter #(.NUM_CORES(N), .AW(AW), .DW(DW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req                (req),
        .we                 (we),
        .addr               (addr_bus),
        .wdata              (wdata_bus),
        .ack                (ack),
        .rdata              (rdata),
        .busy               (busy),
        .dram_write_en      (dram_write_en),
        .dram_addr_write_en (dram_addr_write_en),
        .dram_data_in       (dram_data_in),
        .dram_data_out      (dram_data_out)
    );

    // DRAM: address latched one cycle after addr_write_en, synchronous read every cycle.
    logic [DW-1:0] ram [64];
    logic          aw_q;
    logic [AW-1:0] addr_op;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 40) return DW'(23);
        if (i == 41) return DW'(4);
        return DW'(i * 7 + 3);
    endfunction

    initial begin
        aw_q    <= 1'b0;
        addr_op <= '0;
        for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
    end

    always @(posedge clk) begin
        aw_q <= dram_addr_write_en;
        if (aw_q) addr_op <= dram_data_in;
        if (dram_write_en) ram[addr_op[5:0]] <= dram_data_in;
        dram_data_out <= ram[dram_data_in[5:0]];
    end

    typedef struct packed {
        logic [N-1:0]  ack;
        logic          busy;
        logic          dwe;
        logic          dawe;
        logic [DW-1:0] din;
        logic [DW-1:0] rdata;
    } obs_t;

    obs_t          exp_q[$];
    obs_t          cur_exp = '0;
    logic [DW-1:0] ref_mem [64];
    int            lg_m;
    logic          lw_valid_m;
    logic [AW-1:0] lw_addr_m;
    int            checks = 0;
    int            errors = 0;

    function automatic obs_t mk(input logic [N-1:0] a, input logic b, input logic w,
                                input logic aw, input logic [DW-1:0] d, input logic [DW-1:0] r);
        obs_t o;
        o.ack = a; o.busy = b; o.dwe = w; o.dawe = aw; o.din = d; o.rdata = r;
        return o;
    endfunction

    task automatic check();
        obs_t act;
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        else                  cur_exp = '0;
        act = mk(ack, busy, dram_write_en, dram_addr_write_en, dram_data_in, rdata);
        checks++;
        if (act !== cur_exp) begin
            errors++;
            $display("FAIL cycle_model @%0t: got ack=%b busy=%b we=%b awe=%b din=%h rdata=%h, want ack=%b busy=%b we=%b awe=%b din=%h rdata=%h",
                     $time, act.ack, act.busy, act.dwe, act.dawe, act.din, act.rdata,
                     cur_exp.ack, cur_exp.busy, cur_exp.dwe, cur_exp.dawe, cur_exp.din, cur_exp.rdata);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, expv);
        end
    endtask

    // When the arbiter is idle this cycle, predict the whole next transaction.
    task automatic plan();
        int            w;
        logic [N-1:0]  oh;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (!rst_n || cur_exp.busy) return;
        w = -1;
        for (int k = 1; k <= int'(N) && w < 0; k++)
            if (((req >> ((lg_m + k) % N)) & N'(1)) != '0) w = (lg_m + k) % N;
        if (w < 0) return;
        lg_m = w;
        oh   = N'(1) << w;
        a    = c_addr[w];
        d    = c_wdata[w];
        if (we[w]) begin
            if (!(lw_valid_m && lw_addr_m == a) || HIT_LAT != 1) begin
                exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b1, a, '0));
                exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, a, '0));
                lw_valid_m = 1'b1;
                lw_addr_m  = a;
            end
            exp_q.push_back(mk(oh, 1'b1, 1'b1, 1'b0, d, '0));
            ref_mem[a[5:0]] = d;
        end else begin
            exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, a, '0));
            exp_q.push_back(mk(oh, 1'b1, 1'b0, 1'b0, '0, ref_mem[a[5:0]]));
        end
    endtask

    task automatic step();
        plan();
        @(negedge clk);
        check();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        exp_q.delete();
        cur_exp    = '0;
        lg_m       = N - 1;
        lw_valid_m = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check();
            lit("reset_no_ack", ack, 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output int cyc, output logic [N-1:0] a);
        cyc = 0;
        a   = '0;
        for (int i = 1; i <= 20 && a == '0; i++) begin
            step();
            if (ack != '0) begin
                a   = ack;
                cyc = i;
            end
        end
        if (a == '0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack in 20 cycles, want one");
        end
    endtask

    task automatic set_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[c] = 1'b1; we[c] = w; c_addr[c] = a; c_wdata[c] = d;
    endtask

    task automatic new_params(input int i);
        we[i]      = 1'($urandom_range(0, 1));
        c_addr[i]  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(24, 27)) : AW'($urandom_range(0, 63));
        c_wdata[i] = DW'($urandom);
    endtask

    task automatic drive_random();
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && cur_exp.ack[i]) begin
                if ($urandom_range(0, 3) == 0) new_params(i);
                else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                req[i] = 1'b1;
                new_params(i);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic [N-1:0] a;
        req = '0;
        we  = '0;
        for (int i = 0; i < int'(N); i++) begin
            c_addr[i]  = '0;
            c_wdata[i] = '0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        req = '1;
        do_reset(3);
        req = '0;
        step();
        lit("rst_busy", busy, 0);
        lit("rst_ack", ack, 0);
        lit("rst_dram", {dram_write_en, dram_addr_write_en, dram_data_in}, 0);
        lit("rst_rdata", rdata, 0);

        // Core 2 write then read-back, with DRAM trace.
        set_req(2, 1'b1, 25, 16'h00AA);
        step();
        lit("w_c1_awe", dram_addr_write_en, 1);
        lit("w_c1_din", dram_data_in, 25);
        step();
        lit("w_c2_awe", dram_addr_write_en, 0);
        lit("w_c2_din", dram_data_in, 25);
        step();
        lit("w_c3_ack", ack, 4'b0100);
        lit("w_c3_we", dram_write_en, 1);
        lit("w_c3_din", dram_data_in, 16'h00AA);
        req = '0;
        step();
        set_req(2, 1'b0, 25, '0);
        step();
        step();
        lit("r_ack", ack, 4'b0100);
        lit("r_rdata", rdata, 16'h00AA);
        req = '0;
        step();

        set_req(0, 1'b0, 40, '0);
        wait_ack(cyc, a);
        lit("rd40_lat", cyc, RD_LATENCY);
        lit("rd40_rdata", rdata, 23);
        req = '0;
        step();
        set_req(1, 1'b0, 41, '0);
        wait_ack(cyc, a);
        lit("rd41_rdata", rdata, 4);
        req = '0;
        step();

        // All four cores reading continuously.
        do_reset(2);
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, AW'(40 + i), '0);
        for (int k = 0; k < 5; k++) begin
            wait_ack(cyc, a);
            lit("rr_order", a, N'(1) << (k % N));
            lit("rr_gap", cyc, (k == 0) ? RD_LATENCY : RD_LATENCY + 1);
        end
        req = '0;
        step();

        // Reset during W_LATCH drops the write.
        set_req(1, 1'b1, 30, 16'h1234);
        step();
        step();
        lit("wl_awe", dram_addr_write_en, 0);
        lit("wl_din", dram_data_in, 30);
        do_reset(2);
        set_req(0, 1'b0, 40, '0);
        wait_ack(cyc, a);
        lit("post_rst_grant", a, 4'b0001);
        req[0] = 1'b0;
        wait_ack(cyc, a);
        lit("post_rst_core1", a, 4'b0010);
        req = '0;
        step();

        // Repeated write address, intervening read, then a new address.
        set_req(1, 1'b1, 26, 16'h5555);
        wait_ack(cyc, a);
        lit("c_first_lat", cyc, WR_LATENCY);
        req = '0;
        step();
        set_req(1, 1'b1, 26, 16'h6666);
        wait_ack(cyc, a);
        lit("c_hit_lat", cyc, HIT_LAT);
        lit("c_hit_din", dram_data_in, 16'h6666);
        req = '0;
        step();
        set_req(3, 1'b0, 33, '0);
        wait_ack(cyc, a);
        req = '0;
        step();
        set_req(1, 1'b1, 26, 16'h7777);
        wait_ack(cyc, a);
        lit("c_hit2_lat", cyc, HIT_LAT);
        req = '0;
        step();
        set_req(1, 1'b1, 27, 16'h8888);
        wait_ack(cyc, a);
        lit("c_miss_lat", cyc, WR_LATENCY);
        req = '0;
        step();
        set_req(2, 1'b0, 26, '0);
        wait_ack(cyc, a);
        lit("c_rd26", rdata, 16'h7777);
        req = '0;
        step();

        repeat (4000) begin
            step();
            drive_random();
        end
        req = '0;
        for (int i = 0; i < 30 && (cur_exp.busy || exp_q.size() > 0); i++) step();
        step();
        lit("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

- Round-robin arbiter and sequencer sharing the single-port DRAM between `NUM_CORES` core memory ports.
- Accepts one read or write request per core and grants one at a time.
- Drives the DRAM's three-signal protocol: `write_en`, `addr_write_en`, and the shared `data_in` bus that carries both address and data.
- Returns read data with a one-cycle `ack` to the granted core. Sits between the core load/store units and DRAM.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesting cores (≥2).
- `AW`, 16: address width.
- `DW`, 16: data width; must equal `AW`, since the DRAM shares one bus for address and data.

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_CORES  per-core request; held high until `ack`.
- `we`  in  NUM_CORES  per-core write (1) / read (0); stable while `req` is high.
- `addr`  in  NUM_CORES*AW  per-core address, core i at bits [i*AW +: AW].
- `wdata`  in  NUM_CORES*DW  per-core write data, same packing as `addr`.
- `ack`  out  NUM_CORES  one-hot, single-cycle completion pulse.
- `rdata`  out  DW  read data; valid in the `ack` cycle of a read.
- `busy`  out  1  high whenever state ≠ IDLE.
- `dram_write_en`  out  1  to DRAM `write_en`.
- `dram_addr_write_en`  out  1  to DRAM `addr_write_en`.
- `dram_data_in`  out  DW  to DRAM `data_in`.
- `dram_data_out`  in  DW  from DRAM `data_out`.

## Operation
- FSM states: IDLE, W_ADDR, W_LATCH, W_DATA, R_ADDR, R_RESP.
- In IDLE, if any `req` is high:
  - pick the first requesting index strictly after `last_grant`, wrapping around;
  - register `gidx`, `we`, `addr` and `wdata` for that index;
  - update `last_grant`;
  - go to W_ADDR if `we` is 1, else R_ADDR.
- W_ADDR: `dram_addr_write_en`=1, `dram_data_in`=addr.
- W_LATCH: `dram_addr_write_en`=0, `dram_data_in`=addr. The DRAM latches the address into `addr_op` at the end of this cycle.
- W_DATA: `dram_write_en`=1, `dram_data_in`=wdata, `ack[gidx]`=1; then go to IDLE.
- R_ADDR: `dram_write_en`=0, `dram_data_in`=addr. The DRAM registers `ram[addr]` to `data_out` at the end of this cycle.
- R_RESP: `rdata`=`dram_data_out` (pass-through), `ack[gidx]`=1; then go to IDLE.
- In IDLE, and whenever a DRAM output is not listed above, all DRAM outputs are 0. Idle DRAM reads of address 0 are harmless.
- Core-side and DRAM-side outputs decode only from registered state, `gidx` and latched request data. There is no combinational path from `req`/`addr`/`wdata` to any output.
- A request that is not chosen stays pending. After any grant, each other requester is served within NUM_CORES−1 further grants.
- A core whose `req` is still high in the cycle after its `ack` is treated as a new request.

## Timing
- Reset values: `ack`=0, `rdata`=0, `busy`=0, all DRAM outputs 0, state=IDLE, `last_grant`=NUM_CORES−1 (core 0 has first priority).
- Reset asserted mid-transaction:
  - immediate return to IDLE; the in-flight request is dropped without `ack`;
  - the DRAM may latch `addr_op`=0 from its internal pipeline. This is acceptable.
- Write latency: `req` seen in IDLE at cycle 0 → `ack` at cycle 3.
- Read latency: `req` seen in IDLE at cycle 0 → `ack` and `rdata` at cycle 2.
- Back-to-back: one IDLE cycle between transactions.
- Sustained throughput: 1 write per 4 cycles, 1 read per 3 cycles.
- Simultaneous requests: resolved by round-robin only; `we` has no priority.

## Configuration
- Macro: `DRAM_ARB_ADDR_CACHE_EN`.
- Defined:
  - the arbiter keeps `last_waddr` and a `lw_valid` bit, both cleared by reset;
  - a write whose address equals `last_waddr` with `lw_valid`=1 goes IDLE→W_DATA directly (ack at cycle 1), since DRAM `addr_op` is already correct;
  - every W_LATCH sets `last_waddr`=addr and `lw_valid`=1;
  - reads never change `last_waddr` or `lw_valid`.
- Undefined: every write takes the full W_ADDR→W_LATCH→W_DATA path, and no cache registers exist.

## Structure
- Package `dram_arb_pkg`:
  - state enum `dram_arb_state_t`;
  - default `AW`/`DW` constants;
  - write and read latency constants used by the bench.
- Sub-module `rr_arbiter`:
  - inputs: `req` vector, `last_grant`;
  - outputs: grant index and `any` flag;
  - purely combinational;
  - instantiated once.

## Test plan
- Reset defaults: after reset release, all outputs are 0 and `busy`=0; hold `rst_n` low for 3 cycles while `req`=4'b1111 → no `ack`.
- Single write then read, core 2, NUM_CORES=4:
  - write addr 25, data 16'h00AA → `ack[2]` at cycle 3;
  - DRAM trace: `dram_addr_write_en` in cycle 1, `dram_data_in`=25 in cycles 1–2, `dram_write_en` with 16'h00AA in cycle 3;
  - then read addr 25 → `ack[2]` two cycles later with `rdata`=16'h00AA.
- Read of preloaded location: core 0 reads addr 40 → `rdata`=23; core 1 reads addr 41 → `rdata`=4.
- Fairness: all 4 `req` held high with reads → grant order 0,1,2,3,0; each `ack` spaced 3 cycles apart.
- Reset mid-operation: `rst_n` low in W_LATCH → `ack` never asserted; after release, state is IDLE and the next grant goes to core 0.
- `DRAM_ARB_ADDR_CACHE_EN`:
  - two consecutive writes by core 1 to addr 26 → second `ack` at cycle 1 with no `dram_addr_write_en`;
  - an intervening read to another address keeps the cache hit;
  - a write to addr 27 takes the full path.
